// File: rtl/neuron_activation_fp.sv
// neuron_activation_fp
// Post-MAC activation stage for Q8.8 neurons. A one-cycle result pulse is
// registered (S1), passed through a selectable piecewise-linear activation
// (pass / ReLU / hard-sigmoid / hard-tanh), and buffered in a small FIFO that
// feeds the next layer over a valid/ready handshake. The upstream MAC cannot
// be stalled, so a full FIFO drops the result and raises a sticky overflow.
//
// Optional build macro: NEURON_ACT_SAT_COUNT_EN
//   When defined, adds sat_count[15:0], a saturating count of pushed results
//   whose activation clamp engaged. Cleared together with overflow by clr_ovf.
module neuron_activation_fp #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_BITS  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [DATA_WIDTH-1:0]         x_in,
    input  logic                          x_valid,
    input  logic [1:0]                    act_sel,
    output logic [DATA_WIDTH-1:0]         y_out,
    output logic                          y_valid,
    input  logic                          y_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    input  logic                          clr_ovf
`ifdef NEURON_ACT_SAT_COUNT_EN
    ,
    output logic [15:0]                   sat_count
`endif
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int EXT_W = DATA_WIDTH + 2;

    localparam logic [CNT_W-1:0]             L_DEPTH    = CNT_W'(FIFO_DEPTH);
    localparam logic signed [DATA_WIDTH-1:0] L_ONE      = DATA_WIDTH'(1) << FRAC_BITS;
    localparam logic signed [DATA_WIDTH-1:0] L_NEG_ONE  = -L_ONE;
    localparam logic signed [EXT_W-1:0]      L_ONE_EXT  = EXT_W'(1) << FRAC_BITS;
    localparam logic signed [EXT_W-1:0]      L_HALF_EXT = EXT_W'(1) << (FRAC_BITS - 1);

    // Stage 1 registers
    logic signed [DATA_WIDTH-1:0] r_s1_x;
    logic [1:0]                   r_s1_sel;
    logic                         r_s1_valid;

    // FIFO state
    logic [DATA_WIDTH-1:0]        r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]             r_count;
    logic [DATA_WIDTH-1:0]        r_y_out;
    logic                         r_overflow;

    // Combinational signals
    logic signed [EXT_W-1:0]      w_x_ext;
    logic signed [EXT_W-1:0]      w_t;
    logic [DATA_WIDTH-1:0]        w_act;
    logic                         w_pop;
    logic                         w_push;
    logic                         w_drop;
    logic [PTR_W-1:0]             w_rd_next;

    // Capture the MAC pulse; s1_valid only lives for one cycle per pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_x     <= '0;
            r_s1_sel   <= '0;
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= x_valid;
            if (x_valid) begin
                r_s1_x   <= x_in;
                r_s1_sel <= act_sel;
            end
        end
    end

    // Hard-sigmoid intermediate, widened by two bits so it can never wrap.
    assign w_x_ext = {{2{r_s1_x[DATA_WIDTH-1]}}, r_s1_x};
    assign w_t     = (w_x_ext >>> 2) + L_HALF_EXT;

    // Piecewise-linear activation selected by the sampled act_sel.
    always_comb begin
        w_act = r_s1_x;
        case (r_s1_sel)
            2'd0: w_act = r_s1_x;
            2'd1: w_act = (r_s1_x < 0) ? '0 : r_s1_x;
            2'd2: begin
                if (w_t < 0)
                    w_act = '0;
                else if (w_t > L_ONE_EXT)
                    w_act = L_ONE;
                else
                    w_act = w_t[DATA_WIDTH-1:0];
            end
            default: begin
                if (r_s1_x < L_NEG_ONE)
                    w_act = L_NEG_ONE;
                else if (r_s1_x > L_ONE)
                    w_act = L_ONE;
                else
                    w_act = r_s1_x;
            end
        endcase
    end

    // A pop frees a slot in the same cycle, so a full FIFO can still accept.
    assign w_pop     = (r_count != '0) && y_ready;
    assign w_push    = r_s1_valid && ((r_count < L_DEPTH) || w_pop);
    assign w_drop    = r_s1_valid && !w_push;
    assign w_rd_next = r_rd_ptr + 1'b1;

    // FIFO storage: write-only array, head is mirrored into r_y_out.
    always_ff @(posedge clk) begin
        if (w_push)
            r_mem[r_wr_ptr] <= w_act;
    end

    // Pointers, occupancy, registered head and sticky overflow.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_y_out    <= '0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push)
                r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)
                r_rd_ptr <= w_rd_next;

            if (w_push && !w_pop)
                r_count <= r_count + 1'b1;
            else if (w_pop && !w_push)
                r_count <= r_count - 1'b1;

            // Next head: the stored successor, or the incoming result when
            // it is the only remaining entry (no bubble). Empty holds value.
            if (w_pop) begin
                if (r_count > CNT_W'(1))
                    r_y_out <= r_mem[w_rd_next];
                else if (w_push)
                    r_y_out <= w_act;
            end else if (w_push && (r_count == '0)) begin
                r_y_out <= w_act;
            end

            // A drop in the same cycle as a clear leaves the flag set.
            if (w_drop)
                r_overflow <= 1'b1;
            else if (clr_ovf)
                r_overflow <= 1'b0;
        end
    end

    assign y_out      = r_y_out;
    assign y_valid    = (r_count != '0);
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

`ifdef NEURON_ACT_SAT_COUNT_EN
    logic        w_clamp;
    logic        w_sat_inc;
    logic [15:0] r_sat_count;

    // Flags results where the activation output differs from the linear law.
    always_comb begin
        w_clamp = 1'b0;
        case (r_s1_sel)
            2'd1:    w_clamp = (r_s1_x < 0);
            2'd2:    w_clamp = (w_t < 0) || (w_t > L_ONE_EXT);
            2'd3:    w_clamp = (r_s1_x < L_NEG_ONE) || (r_s1_x > L_ONE);
            default: w_clamp = 1'b0;
        endcase
    end

    assign w_sat_inc = w_push && w_clamp;

    // Saturating clamp counter; a clamp coinciding with clear is still counted.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_sat_count <= '0;
        else if (clr_ovf)
            r_sat_count <= w_sat_inc ? 16'd1 : 16'd0;
        else if (w_sat_inc && (r_sat_count != 16'hFFFF))
            r_sat_count <= r_sat_count + 16'd1;
    end

    assign sat_count = r_sat_count;
`endif

endmodule

// File: tb/tb_neuron_activation_fp.sv
// Testbench for neuron_activation_fp: directed vectors feed a scoreboard
// queue; an independent monitor pops and compares on every handshake.
module tb_neuron_activation_fp;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] x_in;
    logic          x_valid;
    logic [1:0]    act_sel;
    logic [DW-1:0] y_out;
    logic          y_valid;
    logic          y_ready;
    logic [2:0]    fifo_count;
    logic          overflow;
    logic          clr_ovf;
`ifdef NEURON_ACT_SAT_COUNT_EN
    logic [15:0]   sat_count;
`endif

    int tests = 0;
    int fails = 0;
    int pops  = 0;
    logic [DW-1:0] exp_q[$];

    always #5 clk = ~clk;

    neuron_activation_fp #(
        .DATA_WIDTH(16),
        .FRAC_BITS (8),
        .FIFO_DEPTH(4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .x_in      (x_in),
        .x_valid   (x_valid),
        .act_sel   (act_sel),
        .y_out     (y_out),
        .y_valid   (y_valid),
        .y_ready   (y_ready),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
`ifdef NEURON_ACT_SAT_COUNT_EN
        ,
        .sat_count (sat_count)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("[TB] ok   %s = 0x%0h", name, act);
        end
    endtask

    // Monitor: a handshake at the coming edge consumes the expected head.
    always @(negedge clk) begin
        if (rst_n && y_valid && y_ready) begin
            tests++;
            pops++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("[TB] FAIL pop%0d: unexpected output 0x%04h, expected none", pops, y_out);
            end else begin
                logic [DW-1:0] e;
                e = exp_q.pop_front();
                if (y_out !== e) begin
                    fails++;
                    $display("[TB] FAIL pop%0d: y_out=0x%04h expected 0x%04h", pops, y_out, e);
                end else begin
                    $display("[TB] pop%0d y_out=0x%04h", pops, y_out);
                end
            end
        end
    end

    // Issue one pulse; called aligned at posedge+1, returns at next posedge+1.
    task automatic send(input logic [DW-1:0] x, input logic [1:0] sel,
                        input logic [DW-1:0] e, input bit will_push);
        x_in    = x;
        act_sel = sel;
        x_valid = 1'b1;
        if (will_push)
            exp_q.push_back(e);
        @(posedge clk);
        #1;
        x_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || y_valid) && n < 100) begin
            @(negedge clk);
            n++;
        end
        tests++;
        if (n >= 100) begin
            fails++;
            $display("[TB] FAIL drain_timeout: pending=%0d, expected 0", exp_q.size());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n   = 1'b0;
        x_in    = '0;
        x_valid = 1'b0;
        act_sel = 2'd0;
        y_ready = 1'b1;
        clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state while idle
        @(negedge clk);
        check("rst_y_valid", 32'(y_valid), 32'd0);
        check("rst_y_out", 32'(y_out), 32'h0000);
        check("rst_fifo_count", 32'(fifo_count), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;

        // ReLU with latency check
        send(16'h0180, 2'd1, 16'h0180, 1'b1);
        @(negedge clk);
        check("lat_cycle1_y_valid", 32'(y_valid), 32'd0);
        @(negedge clk);
        check("lat_cycle2_y_valid", 32'(y_valid), 32'd1);
        @(posedge clk);
        #1;
        send(16'hFE00, 2'd1, 16'h0000, 1'b1);
        wait_drain();

        // Hard-sigmoid, hard-tanh, pass (back-to-back)
        send(16'h0100, 2'd2, 16'h00C0, 1'b1);
        send(16'h0400, 2'd2, 16'h0100, 1'b1);
        send(16'hFC00, 2'd2, 16'h0000, 1'b1);
        send(16'h0000, 2'd2, 16'h0080, 1'b1);
        send(16'h0300, 2'd3, 16'h0100, 1'b1);
        send(16'hFF80, 2'd3, 16'hFF80, 1'b1);
        send(16'hF000, 2'd3, 16'hFF00, 1'b1);
        send(16'h7FFF, 2'd0, 16'h7FFF, 1'b1);
        wait_drain();

        // Overflow: six pulses into a stalled four-entry FIFO
        y_ready = 1'b0;
        for (int i = 1; i <= 6; i++)
            send(16'(i), 2'd0, 16'(i), i <= 4);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("ovf_fifo_count", 32'(fifo_count), 32'd4);
        check("ovf_overflow", 32'(overflow), 32'd1);
        check("ovf_head_stable", 32'(y_out), 32'h0001);
        @(posedge clk);
        #1;
        y_ready = 1'b1;
        wait_drain();
        check("ovf_sticky_after_drain", 32'(overflow), 32'd1);
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        @(negedge clk);
        check("ovf_cleared", 32'(overflow), 32'd0);
        @(posedge clk);
        #1;

        // Full FIFO: push and pop land on the same edge
        y_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            send(16'h0010 + 16'(i), 2'd0, 16'h0010 + 16'(i), 1'b1);
        y_ready = 1'b1;
        @(posedge clk);
        #1;
        y_ready = 1'b0;
        @(negedge clk);
        check("full_pp_fifo_count", 32'(fifo_count), 32'd4);
        check("full_pp_overflow", 32'(overflow), 32'd0);
        check("full_pp_head", 32'(y_out), 32'h0011);
        @(posedge clk);
        #1;
        y_ready = 1'b1;
        wait_drain();

`ifdef NEURON_ACT_SAT_COUNT_EN
        clr_ovf = 1'b1;
        @(posedge clk);
        #1;
        clr_ovf = 1'b0;
        send(16'hFF00, 2'd1, 16'h0000, 1'b1);
        send(16'h0100, 2'd1, 16'h0100, 1'b1);
        send(16'h8000, 2'd1, 16'h0000, 1'b1);
        wait_drain();
        check("sat_count", 32'(sat_count), 32'd2);
`endif

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        check("final_y_valid", 32'(y_valid), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/neuron_activation_fp.md
Name: neuron_activation_fp

Overview:
Downstream stage of the Q8.8 sequential MAC neuron. Consumes the neuron's one-cycle result pulse and applies a selectable piecewise-linear activation: pass, ReLU, hard-sigmoid or hard-tanh. Results are buffered in a small FIFO and handed to the next layer with a valid/ready handshake. The MAC has no backpressure, so this block absorbs bursts and flags any dropped results.

Parameters:
DATA_WIDTH, 16, sample width (signed Q8.8)
FRAC_BITS, 8, fractional bits; 1.0 = 1<<FRAC_BITS
FIFO_DEPTH, 4, output FIFO entries, power of 2, >=2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
x_in  in  DATA_WIDTH  signed Q8.8 pre-activation value from neuron
x_valid  in  1  one-cycle pulse, x_in valid; no ready returned
act_sel  in  2  activation, sampled with x_valid: 0 pass, 1 ReLU, 2 hard-sigmoid, 3 hard-tanh
y_out  out  DATA_WIDTH  signed Q8.8 activated value (FIFO head)
y_valid  out  1  FIFO non-empty
y_ready  in  1  consumer accepts y_out when y_valid&&y_ready
fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy
overflow  out  1  sticky: a result was dropped
clr_ovf  in  1  synchronous clear of overflow (and sat_count if present)

Behaviour:
- Reset (async, rst_n low):
  - Stage-1 register and FIFO pointers/count cleared.
  - y_valid=0, y_out=0, fifo_count=0, overflow=0.
  - Reset mid-operation discards all in-flight and buffered results.
- Stage S1, edge E0: on x_valid, register x_in and act_sel, set s1_valid. Without x_valid, s1_valid=0.
- Stage S2, edge E1: activation computed combinationally from S1; result pushed to FIFO if s1_valid.
- Latency: x_valid at edge E0 → y_valid high after E1 (2 cycles) when FIFO empty.
- Throughput: one sample per cycle.
- Activation arithmetic (ONE = 1<<FRAC_BITS):
  - pass: y = x.
  - ReLU: y = (x<0) ? 0 : x.
  - hard-sigmoid: t = (x>>>2) + ONE/2 at DATA_WIDTH+2 bits; y = clamp(t, 0, ONE).
  - hard-tanh: y = clamp(x, -ONE, +ONE).
  - Arithmetic shift only; no rounding; no wrap-around possible.
- FIFO:
  - Output is the head, registered.
  - pop = y_valid && y_ready.
  - push = s1_valid && (count<FIFO_DEPTH || pop).
  - Pointers wrap modulo FIFO_DEPTH.
- Simultaneous push and pop:
  - Count unchanged; legal when full.
  - When count==1, the new entry becomes head on the next cycle with no bubble.
- Full with no pop and s1_valid: result dropped, overflow set to 1, FIFO contents unchanged.
- overflow stays set until a cycle with clr_ovf=1. If a drop and clr_ovf occur in the same cycle, the drop wins and overflow=1.
- Empty:
  - y_valid=0 and y_out holds its last value (0 after reset).
  - y_ready is ignored.
- y_out is stable while y_valid=1 and y_ready=0.
- act_sel is sampled only with x_valid; changing it has no effect on stored entries.

Optional Feature:
Macro NEURON_ACT_SAT_COUNT_EN.
- Defined:
  - Adds output sat_count[15:0].
  - Increments once per pushed result whose activation clamp engaged: ReLU negative input, hard-sigmoid t<0 or t>ONE, hard-tanh |x|>ONE.
  - Saturates at 0xFFFF; cleared by clr_ovf.
  - Dropped results are not counted.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset then idle, y_ready=1 → y_valid=0, y_out=0x0000, fifo_count=0, overflow=0.
- ReLU, y_ready=1:
  - x_in=0x0180 → y_out=0x0180, y_valid high exactly 2 cycles after the x_valid cycle.
  - x_in=0xFE00 → 0x0000.
- Hard-sigmoid:
  - x=0x0100 → 0x00C0.
  - x=0x0400 → 0x0100.
  - x=0xFC00 → 0x0000.
  - x=0x0000 → 0x0080.
- Hard-tanh:
  - x=0x0300 → 0x0100.
  - x=0xFF80 → 0xFF80.
  - x=0xF000 → 0xFF00.
  - Pass mode, x=0x7FFF → 0x7FFF.
- Overflow: y_ready=0, six back-to-back pulses x=1..6 (pass).
  - fifo_count=4, overflow=1.
  - Then y_ready=1 → pops 1,2,3,4 in order.
  - clr_ovf pulse → overflow=0.
- Full FIFO with y_ready=1 and x_valid on the same cycle → no drop, count stays 4, overflow stays 0, order preserved. With NEURON_ACT_SAT_COUNT_EN, ReLU inputs 0xFF00,0x0100,0x8000 → sat_count=2.
